// File: rtl/pipe_ctrl.sv
// Pipeline control: merges per-source stall levels into a thermometer stall bus,
// sequences multi-cycle flushes with a redirect PC, and tracks stall duration and stats.
module pipe_ctrl #(
  parameter int NSTAGE    = 6,
  parameter int NREQ      = 4,
  parameter int LW        = 3,
  parameter int FLUSH_CYC = 1,
  parameter int TIMEOUT   = 1024,
  parameter int CNTW      = 32,
  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    stall_req,
  input  logic [NREQ*LW-1:0] stall_lvl,
  input  logic               flush_req,
  input  logic [31:0]        flush_pc,
  input  logic               clr_stat,
  output logic [NSTAGE-1:0]  stall,
  output logic [SW-1:0]      stall_src,
  output logic               flush,
  output logic [31:0]        new_pc,
  output logic               stall_timeout,
  output logic [CNTW-1:0]    stall_cycles,
  output logic [CNTW-1:0]    flush_count,
  output logic               state_dbg
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  localparam int FCW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam int RLW = $clog2(TIMEOUT + 1);
  localparam logic [LW-1:0]  LVL_MAX  = LW'(NSTAGE);
  localparam logic [FCW-1:0] CNT_INIT = FCW'(FLUSH_CYC - 1);
  localparam logic [RLW-1:0] RUN_MAX  = RLW'(TIMEOUT);

  state_t            state, state_d;
  logic [FCW-1:0]    flush_cnt, flush_cnt_d;
  logic [31:0]       pc_q, pc_d;
  logic [RLW-1:0]    run_len;
  logic [LW-1:0]     best, lvl;
  logic [SW-1:0]     best_src;
  logic              found;
  logic [NSTAGE-1:0] stall_raw;
  logic              stall_active;

  // Highest clamped level wins; strict '>' keeps the lowest index on ties.
  always_comb begin
    best      = '0;
    best_src  = '0;
    found     = 1'b0;
    lvl       = '0;
    stall_raw = '0;
    for (int i = 0; i < NREQ; i++) begin
      lvl = stall_lvl[i*LW +: LW];
      if (lvl > LVL_MAX) lvl = LVL_MAX;
      if (stall_req[i] && (!found || lvl > best)) begin
        best     = lvl;
        best_src = SW'(i);
        found    = 1'b1;
      end
    end
    for (int j = 0; j < NSTAGE; j++) stall_raw[j] = (j < int'(best));
  end

  // Flush sequencer; a new request always restarts the window with its own PC.
  always_comb begin
    state_d     = state;
    flush_cnt_d = flush_cnt;
    pc_d        = pc_q;
    flush       = flush_req | (state == FLUSH);
    new_pc      = flush_req ? flush_pc : pc_q;
    if (flush_req) begin
      pc_d = flush_pc;
      if (FLUSH_CYC > 1) begin
        state_d     = FLUSH;
        flush_cnt_d = CNT_INIT;
      end
    end else if (state == FLUSH) begin
      if (flush_cnt <= FCW'(1)) begin
        state_d     = RUN;
        flush_cnt_d = '0;
      end else begin
        flush_cnt_d = flush_cnt - 1'b1;
      end
    end
  end

  // Flush wins: stall requests seen during a flush are simply dropped.
  assign stall        = flush ? '0 : stall_raw;
  assign stall_src    = flush ? '0 : best_src;
  assign stall_active = |stall;
  assign state_dbg    = (state == FLUSH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      flush_cnt <= '0;
      pc_q      <= '0;
    end else begin
      state     <= state_d;
      flush_cnt <= flush_cnt_d;
      pc_q      <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_stat) begin
      run_len       <= '0;
      stall_timeout <= 1'b0;
      stall_cycles  <= '0;
      flush_count   <= '0;
    end else begin
      if (stall_active) begin
        stall_cycles <= stall_cycles + 1'b1;
        if (run_len != RUN_MAX) run_len <= run_len + 1'b1;
        if (run_len >= RUN_MAX - 1'b1) stall_timeout <= 1'b1;
      end else begin
        run_len <= '0;
      end
      if (flush_req) flush_count <= flush_count + 1'b1;
    end
  end

endmodule
